// File: rtl/window_feeder_if.sv
// Shift-interface bundle between window_feeder, pixel memory and the window shift registers.
// Master is the feeder; slave is the surrounding datapath/memory side.
interface window_feeder_if #(
  parameter int unsigned B  = 8,
  parameter int unsigned AW = 12,
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 6
) ();
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [B-1:0]  mem_rdata;
  logic [B-1:0]  din;
  logic          up_en;
  logic          down_en;
  logic          win_valid;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  modport master (
    input  start, hold, mem_rdata,
    output busy, done, mem_rd, mem_addr, din, up_en, down_en, win_valid, cx, cy
  );

  modport slave (
    output start, hold, mem_rdata,
    input  busy, done, mem_rd, mem_addr, din, up_en, down_en, win_valid, cx, cy
  );
endinterface

// File: rtl/window_feeder.sv
// Serpentine scan sequencer feeding an N-tap window shift register from pixel memory.
// Define WINDOW_FEEDER_EDGE_REPLICATE_EN to clamp out-of-image slots instead of zero padding.
module window_feeder #(
  parameter int unsigned N  = 11,
  parameter int unsigned B  = 8,
  parameter int unsigned W  = 64,
  parameter int unsigned H  = 48,
  parameter int unsigned AW = 12,
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  window_feeder_if.master bus
);

  localparam int unsigned Half  = (N - 1) / 2;
  localparam int unsigned Slots = N - 1 + W;
  localparam int unsigned KW    = $clog2(Slots);
  localparam logic [KW-1:0] KLast = KW'(Slots - 1);
  localparam logic [KW-1:0] KHalf = KW'(Half);
  localparam logic [KW-1:0] KEdge = KW'(W + Half);
  localparam logic [KW-1:0] KWin  = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  typedef struct packed {
    logic          pad;
    logic          odd;
    logic          win;
    logic          last;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
  } slot_t;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [YW-1:0] y_q, y_d;

  logic          adv, issue, row_odd, in_img, last_slot, row_last, done;
  logic [KW-1:0] kc;
  logic [XW-1:0] x_raw, x_rd;
  slot_t         slot;

  slot_t         s1_q, s2_q, s3_q;
  logic          s1_vld_q, s2_vld_q, s3_vld_q;
  logic [B-1:0]  skid_q, din_q;
  logic          skid_vld_q;

  assign adv       = ~bus.hold;
  assign issue     = (state_q == StScan) && adv;
  assign row_odd   = y_q[0];
  assign in_img    = (k_q >= KHalf) && (k_q < KEdge);
  assign last_slot = (k_q == KLast);
  assign row_last  = (y_q == YW'(H - 1));
  assign kc        = k_q - KWin;
  assign x_raw     = row_odd ? XW'(W - 1 + Half) - XW'(k_q) : XW'(k_q) - XW'(Half);

`ifdef WINDOW_FEEDER_EDGE_REPLICATE_EN
  // Left pad of an even row and right pad of an odd row both sit before column 0.
  assign x_rd       = in_img ? x_raw : (((k_q < KHalf) != row_odd) ? '0 : XW'(W - 1));
  assign bus.mem_rd = issue;
  assign slot.pad   = 1'b0;
`else
  assign x_rd       = x_raw;
  assign bus.mem_rd = issue && in_img;
  assign slot.pad   = ~in_img;
`endif

  assign bus.mem_addr = bus.mem_rd ? (AW'(y_q) * AW'(W) + AW'(x_rd)) : '0;

  assign slot.odd  = row_odd;
  assign slot.win  = (k_q >= KWin);
  assign slot.last = row_last && last_slot;
  assign slot.cx   = row_odd ? XW'(W - 1) - XW'(kc) : XW'(kc);
  assign slot.cy   = y_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StScan;
          k_d     = '0;
          y_d     = '0;
        end
      end
      StScan: begin
        if (adv) begin
          if (last_slot) begin
            k_d = '0;
            if (row_last) state_d = StDrain;
            else          y_d     = y_q + YW'(1);
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StDrain: begin
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      k_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      y_q     <= y_d;
    end
  end

  // Three-stage slot pipeline (issue, capture, shift); hold freezes every stage at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      din_q      <= '0;
    end else if (adv) begin
      s1_vld_q   <= issue;
      s1_q       <= slot;
      s2_vld_q   <= s1_vld_q;
      s2_q       <= s1_q;
      s3_vld_q   <= s2_vld_q && s2_q.win;
      s3_q       <= s2_q;
      skid_vld_q <= 1'b0;
      if (s1_vld_q) din_q <= s1_q.pad ? '0 : (skid_vld_q ? skid_q : bus.mem_rdata);
    end else if (s1_vld_q && !skid_vld_q) begin
      // Read data is only on the bus for one cycle; park it until the stall clears.
      skid_q     <= bus.mem_rdata;
      skid_vld_q <= 1'b1;
    end
  end

  assign done          = s3_vld_q && adv && s3_q.last;
  assign bus.done      = done;
  assign bus.busy      = (state_q != StIdle);
  assign bus.din       = din_q;
  assign bus.up_en     = s2_vld_q && !s2_q.odd && adv;
  assign bus.down_en   = s2_vld_q && s2_q.odd && adv;
  assign bus.win_valid = s3_vld_q && adv;
  assign bus.cx        = s3_q.cx;
  assign bus.cy        = s3_q.cy;

endmodule

// File: tb/tb_window_feeder.sv
// Randomized bench for window_feeder: image-level reference model plus a model shift register
// whose contents are compared against the expected window at every win_valid.
module tb_window_feeder;
  localparam int N     = 3;
  localparam int B     = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int AW    = 12;
  localparam int XW    = 7;
  localparam int YW    = 6;
  localparam int Hh    = (N - 1) / 2;
  localparam int Slots = N - 1 + W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  logic [B-1:0] mem [W*H];
  logic [B-1:0] sr  [N];
  int exp_din[$];
  bit exp_up[$];
  int exp_addr[$];
  int exp_cx[$];
  int exp_cy[$];

  window_feeder_if #(.B(B), .AW(AW), .XW(XW), .YW(YW)) bus ();

  window_feeder #(
    .N(N), .B(B), .W(W), .H(H), .AW(AW), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pix(int x, int y);
`ifdef WINDOW_FEEDER_EDGE_REPLICATE_EN
    if (x < 0) x = 0;
    if (x >= W) x = W - 1;
`else
    if (x < 0 || x >= W) return 0;
`endif
    return int'(mem[y*W + x]);
  endfunction

  task automatic build_expect();
    int x, xr;
    exp_din.delete(); exp_up.delete(); exp_addr.delete(); exp_cx.delete(); exp_cy.delete();
    for (int y = 0; y < H; y++) begin
      for (int k = 0; k < Slots; k++) begin
        x  = (y % 2 == 0) ? k - Hh : W - 1 + Hh - k;
        xr = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
        exp_din.push_back(pix(x, y));
        exp_up.push_back(y % 2 == 0);
`ifdef WINDOW_FEEDER_EDGE_REPLICATE_EN
        exp_addr.push_back(y*W + xr);
`else
        if (x == xr) exp_addr.push_back(y*W + x);
`endif
        if (k >= N - 1) begin
          exp_cx.push_back((y % 2 == 0) ? k - (N - 1) : W - 1 - (k - (N - 1)));
          exp_cy.push_back(y);
        end
      end
    end
  endtask

  // Pixel memory: data valid one cycle after the strobe, junk otherwise.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : B'($urandom);
    end
  end

  // Monitor: checks reads, shifts and windows against the model queues.
  initial begin
    int ecx, ecy;
    bit eu;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.hold)
          check("hold_quiet", {bus.mem_rd, bus.up_en, bus.down_en, bus.win_valid}, 0);
        if (bus.mem_rd) begin
          check("read_expected", exp_addr.size() > 0, 1);
          if (exp_addr.size() > 0) check("mem_addr", bus.mem_addr, exp_addr.pop_front());
        end
        if (bus.win_valid) begin
          check("win_expected", exp_cx.size() > 0, 1);
          if (exp_cx.size() > 0) begin
            ecx = exp_cx.pop_front();
            ecy = exp_cy.pop_front();
            check("cx", bus.cx, ecx);
            check("cy", bus.cy, ecy);
            for (int j = 0; j < N; j++) check("window", sr[N-1-j], pix(ecx - Hh + j, ecy));
            check("done_last", bus.done, exp_cx.size() == 0);
          end
        end else begin
          check("done_stray", bus.done, 0);
        end
        if (bus.up_en || bus.down_en) begin
          check("shift_expected", exp_din.size() > 0, 1);
          if (exp_din.size() > 0) begin
            eu = exp_up.pop_front();
            check("direction", {bus.up_en, bus.down_en}, eu ? 2'b10 : 2'b01);
            check("din", bus.din, exp_din.pop_front());
          end
          if (bus.up_en) begin
            for (int i = N - 1; i > 0; i--) sr[i] = sr[i-1];
            sr[0] = bus.din;
          end else begin
            for (int i = 0; i < N - 1; i++) sr[i] = sr[i+1];
            sr[N-1] = bus.din;
          end
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {bus.busy, bus.done, bus.mem_rd, bus.up_en, bus.down_en, bus.win_valid}, 0);
    check({tag, "_din"}, bus.din, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_cxcy"}, {bus.cx, bus.cy}, 0);
  endtask

  // mode 0: no stall, 1: random hold, 2: one 3-cycle hold right after a read, 3: start while busy
  task automatic run_frame(input int mode);
    int cnt, nhold, hold_left;
    bit did, prev_rd;
    build_expect();
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("idle_before_start", bus.busy, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cnt = 0; nhold = 0; hold_left = 0; did = 0; prev_rd = 0;
    while (bus.busy && cnt < 1000) begin
      cnt++;
      if (mode == 1) begin
        bus.hold = ($urandom_range(3) == 0);
      end else if (mode == 2) begin
        if (hold_left > 0) begin
          bus.hold = 1'b1;
          hold_left--;
        end else if (!did && prev_rd && cnt > Slots) begin
          bus.hold = 1'b1;
          hold_left = 2;
          did = 1'b1;
        end else begin
          bus.hold = 1'b0;
        end
      end else begin
        bus.hold = 1'b0;
      end
      bus.start = (mode == 3 && (cnt == 5 || cnt == Slots + 1));
      if (bus.hold) nhold++;
      #1 prev_rd = bus.mem_rd;
      @(posedge clk); #1;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    check("frame_len", cnt, H*Slots + 3 + nhold);
    check("queues_drained", exp_din.size() + exp_addr.size() + exp_cx.size(), 0);
  endtask

  task automatic abort_frame();
    build_expect();
    mon_en = 1'b1;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (Slots + 3) @(posedge clk);
    #1 mon_en = 1'b0;
    rstn = 1'b0;
    #1 check_idle("abort");
    @(posedge clk); #1 check_idle("abort_held");
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) mem[i] = B'(i + 1);
    for (int i = 0; i < N; i++) sr[i] = '0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    rstn = 1'b1;
    run_frame(0);
    run_frame(2);
    run_frame(3);
    abort_frame();
    run_frame(0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < W*H; i++) mem[i] = B'($urandom);
      run_frame(1);
    end
    run_frame(2);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_feeder.md
# window_feeder

Serpentine-scan sequencer that reads an image from pixel memory and drives the `din`/`up_en`/`down_en` shift interface of a row of N-tap window shift registers in the convolution datapath. Even rows stream left-to-right with `up_en`, odd rows right-to-left with `down_en`. Out-of-image pixels are padded so every window is centered on a valid pixel. It flags `win_valid` with the center coordinate whenever the attached shift register holds a complete window.

## Interface
- N, 11: window width in taps, odd, ≥3; h=(N-1)/2.
- B, 8: pixel width.
- W, 64: image width, ≥N.
- H, 48: image height, ≥1.
- AW, 12: memory address width; W*H ≤ 2^AW.
- XW, 7 / YW, 6: coordinate widths; 2^XW > W, 2^YW > H.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- hold  in  1  downstream stall.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.
- mem_rd  out  1  pixel read strobe.
- mem_addr  out  AW  read address, y*W+x.
- mem_rdata  in  B  read data, valid exactly one cycle after mem_rd.
- din  out  B  pixel to shift register.
- up_en  out  1  shift toward MSB (even rows).
- down_en  out  1  shift toward LSB (odd rows).
- win_valid  out  1  shift register holds window centered at (cx,cy).
- cx  out  XW  window center column.
- cy  out  YW  window center row.

## Operation
- States: IDLE, SCAN, DRAIN. All outputs reset to 0; state resets to IDLE.
- IDLE→SCAN on start=1; y=0, k=0.
- SCAN: one slot per cycle when hold=0. Slot k runs 0..N-2+W.
  - Even row: x=k-h. Odd row: x=W-1+h-k.
- Slot with 0≤x<W: mem_rd=1, mem_addr=y*W+x. Otherwise it is a pad slot: no read, and the pixel is 0.
- k wraps to 0 at N-2+W and y increments with no bubble. After slot N-2+W of row H-1, go to DRAIN.
- DRAIN→IDLE when the last shift has been issued and win_valid has fired.
- Each slot produces exactly one shift, in slot order. The direction comes from the row parity of that slot, not the current row.
- After the shift of slot k≥N-1, the register holds pixels x_c-h..x_c+h, with x_c=k-h-(N-1)+h on even rows (i.e. k-(N-1)) and W-1-(k-(N-1)) on odd rows.
  - Even rows: dout[0] is the rightmost pixel.
  - Odd rows: dout[N-1] is the leftmost pixel.
- win_valid fires the cycle after that shift, with cx=x_c and cy=row. Slots k<N-1 are priming slots and produce no win_valid.
- start while busy is ignored.

## Timing
- Slot issued in cycle t. Read data is captured at t+1. up_en or down_en is asserted with din in t+2, and the shift occurs at the t+2→t+3 edge. win_valid, cx and cy are asserted in t+3.
- First mem_rd (or first pad slot) occurs in the cycle after start is sampled. busy=1 from that cycle through the done cycle.
- Unstalled throughput is one shift per cycle. A frame takes H*(N-1+W) slot cycles plus 3.
- hold=1 in cycle c:
  - mem_rd, up_en, down_en and win_valid are 0 in c. The enables are gated combinationally by hold.
  - No slot advances.
  - A read issued in c-1 is captured into a 1-entry skid buffer.
  - On release, the stream resumes in order with no loss or duplication.
- done pulses in the same cycle as the final win_valid (cx=0, cy=H-1 if H is even; cx=W-1 if H is odd). busy falls in the next cycle.
- rstn low mid-frame: immediate return to IDLE, outputs 0, in-flight read discarded.

## Configuration
- WINDOW_FEEDER_EDGE_REPLICATE_EN defined: out-of-image slots read the clamped address y*W+min(max(x,0),W-1). They use the normal read path and latency, so the windows are edge-replicated.
- Undefined: out-of-image slots are zero pads and issue no read.

## Test plan
- N=3, W=4, H=1, memory[i]=i+1, start -> din sequence 0,1,2,3,4,0 with up_en; win_valid ×4 with cx=0..3; windows {0,1,2},{1,2,3},{2,3,4},{3,4,0}; done with final win_valid.
- Same parameters, H=2 -> row 1 uses down_en, reads addresses 7,6,5,4, cx sequence 3,2,1,0 with cy=1; no idle cycle between rows.
- hold=1 for 3 cycles, asserted one cycle after a mem_rd -> no enables or reads during hold; din sequence identical to the unstalled run.
- rstn pulsed low mid-row 1 -> all outputs 0; a new start then produces a full correct frame from (0,0).
- start asserted while busy -> ignored; frame length unchanged.
- Macro defined, N=3, W=4 -> row 0 din sequence 1,1,2,3,4,4; first window {1,1,2}.
